// File: rtl/barrel_demux.sv
// barrel_demux: routes a stream of words to one of NCH channels selected per word.
// A two-entry buffer (output register plus skid register) gives full throughput while
// keeping in_ready a pure function of state. Words with an out-of-range select code
// are swallowed, counted and flagged.
module barrel_demux #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned NCH   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [3:0]       in_sel,
  output logic [NCH-1:0]   out_valid,
  input  logic [NCH-1:0]   out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             sel_err,
  output logic [7:0]       drop_cnt
);

  typedef enum logic [1:0] {
    StEmpty,
    StFull,
    StSkid
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [3:0]         out_sel_q, out_sel_d;
  logic [WIDTH-1:0]   skid_data_q, skid_data_d;
  logic [3:0]         skid_sel_q, skid_sel_d;
  logic               sel_err_q, sel_err_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;

  logic in_fire;
  logic sel_ok;
  logic in_ok;
  logic in_bad;
  logic out_fire;

  // Handshake decode; out_valid is one-hot so masking with out_ready ignores other channels.
  always_comb begin
    in_ready = (state_q != StSkid);
    in_fire  = in_valid && in_ready;
    sel_ok   = (32'(in_sel) < NCH);
    in_ok    = in_fire && sel_ok;
    in_bad   = in_fire && !sel_ok;
    out_fire = |(out_valid & out_ready);
  end

  // One-hot channel decode of the output register.
  always_comb begin
    out_valid = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      out_valid[k] = (state_q != StEmpty) && (32'(out_sel_q) == k);
    end
  end

  // Buffer state machine: next state and register loads.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    unique case (state_q)
      StEmpty: begin
        if (in_ok) begin
          out_data_d = in_data;
          out_sel_d  = in_sel;
          state_d    = StFull;
        end
      end
      StFull: begin
        if (out_fire && in_ok) begin
          // Replace in place: no bubble between consecutive words.
          out_data_d = in_data;
          out_sel_d  = in_sel;
        end else if (out_fire) begin
          state_d = StEmpty;
        end else if (in_ok) begin
          skid_data_d = in_data;
          skid_sel_d  = in_sel;
          state_d     = StSkid;
        end
      end
      StSkid: begin
        // in_ready is low here, so only the drain event matters.
        if (out_fire) begin
          out_data_d = skid_data_q;
          out_sel_d  = skid_sel_q;
          state_d    = StFull;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Invalid-select bookkeeping: sticky flag and saturating drop counter.
  always_comb begin
    sel_err_d  = sel_err_q;
    drop_cnt_d = drop_cnt_q;
    if (in_bad) begin
      sel_err_d = 1'b1;
      if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
  end

  // State and data registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      sel_err_q   <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      sel_err_q   <= sel_err_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // out_data holds the last offered word, including while empty.
  always_comb begin
    out_data = out_data_q;
    sel_err  = sel_err_q;
    drop_cnt = drop_cnt_q;
  end

endmodule

// File: tb/tb_barrel_demux.sv
// Self-checking bench for barrel_demux: vector table plus hand-written corner sequences,
// with a scoreboard queue checking order and content of every delivered word.
module tb_barrel_demux;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned NCH   = 10;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [3:0]       in_sel;
  logic [NCH-1:0]   out_valid;
  logic [NCH-1:0]   out_ready;
  logic [WIDTH-1:0] out_data;
  logic             sel_err;
  logic [7:0]       drop_cnt;

  barrel_demux #(
    .WIDTH(WIDTH),
    .NCH  (NCH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .sel_err  (sel_err),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0]  sel;
    logic [63:0] data;
  } word_t;

  word_t sb_q[$];

  typedef struct {
    logic [3:0]  sel;
    logic [63:0] data;
    logic [9:0]  exp_valid;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock. At the falling edge, observe the handshakes that the coming
  // rising edge will perform and run the scoreboard; return 1 time unit after the edge.
  task automatic step();
    word_t exp_w;
    @(negedge clk);
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if ((out_valid & out_ready) != '0) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_word", 64'(out_valid), 64'd0);
        end else begin
          exp_w = sb_q.pop_front();
          chk("sb_channel", 64'(out_valid), 64'(1) << exp_w.sel);
          chk("sb_data", out_data, exp_w.data);
        end
      end
      if (in_valid && in_ready && (32'(in_sel) < NCH)) begin
        exp_w.sel  = in_sel;
        exp_w.data = in_data;
        sb_q.push_back(exp_w);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] sel, input logic [63:0] data);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    step();
    in_valid = 1'b0;
  endtask

  logic [63:0] held;

  initial begin
    vecs[0] = '{4'd3,  64'h0123_4567_89AB_CDEF, 10'h008, 64'h0123_4567_89AB_CDEF};
    vecs[1] = '{4'd0,  64'hA5A5_A5A5_5A5A_5A5A, 10'h001, 64'hA5A5_A5A5_5A5A_5A5A};
    vecs[2] = '{4'd9,  64'hFFFF_FFFF_FFFF_FFFF, 10'h200, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[3] = '{4'd12, 64'h0000_0000_0000_DEAD, 10'h000, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[4] = '{4'd15, 64'h0000_0000_0000_BEEF, 10'h000, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[5] = '{4'd2,  64'h0000_0000_0000_1234, 10'h004, 64'h0000_0000_0000_1234};
    vecs[6] = '{4'd10, 64'h0000_0000_0000_5555, 10'h000, 64'h0000_0000_0000_1234};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_data   = '0;
    out_ready = '0;
    step();
    step();
    rst_n = 1'b1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data", out_data, 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_sel_err", 64'(sel_err), 64'd0);
    chk("reset_drop_cnt", 64'(drop_cnt), 64'd0);

    // Single words through the table, downstream always ready.
    out_ready = '1;
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].sel, vecs[i].data);
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_data);
      step();
      chk($sformatf("vec%0d_drained", i), 64'(out_valid), 64'd0);
      chk($sformatf("vec%0d_empty_data", i), out_data, vecs[i].exp_data);
    end
    chk("table_sel_err", 64'(sel_err), 64'd1);
    chk("table_drop_cnt", 64'(drop_cnt), 64'd3);

    // Back-to-back streaming across every channel.
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_sel  = 4'(i);
      in_data = {$urandom, $urandom};
      step();
      chk($sformatf("stream%0d_out_valid", i), 64'(out_valid), 64'(1) << i);
      chk($sformatf("stream%0d_in_ready", i), 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drained", 64'(out_valid), 64'd0);

    // Backpressure into the skid register, then release channel 5 only.
    out_ready = '0;
    send(4'd5, 64'h5555_0000_0000_0005);
    chk("bp_first_in_ready", 64'(in_ready), 64'd1);
    send(4'd7, 64'h7777_0000_0000_0007);
    chk("bp_skid_in_ready", 64'(in_ready), 64'd0);
    chk("bp_skid_out_valid", 64'(out_valid), 64'h020);
    step();
    chk("bp_hold_out_valid", 64'(out_valid), 64'h020);
    chk("bp_hold_out_data", out_data, 64'h5555_0000_0000_0005);
    out_ready = 10'h020;
    step();
    chk("bp_release_out_valid", 64'(out_valid), 64'h080);
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    chk("bp_release_out_data", out_data, 64'h7777_0000_0000_0007);
    out_ready = '1;
    step();
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Ready on the wrong channel must not drain the word.
    out_ready = '0;
    send(4'd4, 64'h4444_4444_4444_4444);
    out_ready = 10'h040;
    held      = out_data;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("wrong_ch%0d_out_valid", i), 64'(out_valid), 64'h010);
      chk($sformatf("wrong_ch%0d_out_data", i), out_data, held);
    end
    out_ready = 10'h010;
    step();
    chk("wrong_ch_drained", 64'(out_valid), 64'd0);

    // Drop counter saturation.
    out_ready = '1;
    in_valid  = 1'b1;
    in_sel    = 4'd11;
    for (int i = 0; i < 300; i++) begin
      in_data = 64'(i);
      step();
    end
    in_valid = 1'b0;
    chk("sat_drop_cnt", 64'(drop_cnt), 64'd255);
    chk("sat_sel_err", 64'(sel_err), 64'd1);
    chk("sat_out_valid", 64'(out_valid), 64'd0);

    // Reset while in SKID discards both held words.
    out_ready = '0;
    send(4'd1, 64'h1111_1111_1111_1111);
    send(4'd8, 64'h8888_8888_8888_8888);
    chk("rst_pre_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_sel_err", 64'(sel_err), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    rst_n     = 1'b1;
    out_ready = '1;
    step();
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    chk("sb_leftover", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/barrel_demux.md
BARREL_DEMUX -- requirements
Module: barrel_demux

Interface
REQ-001 Parameter WIDTH, default 64: data word width in bits.
REQ-002 Parameter NCH, default 10: number of output channels; select codes 0..NCH-1 are valid.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  the upstream word is present.
REQ-006 in_ready  output  1  the block accepts a word this cycle.
REQ-007 in_data  input  WIDTH  the upstream word.
REQ-008 in_sel  input  4  the destination channel code.
REQ-009 out_valid  output  NCH  one-hot or zero; bit k high means out_data is offered to channel k.
REQ-010 out_ready  input  NCH  per-channel downstream ready.
REQ-011 out_data  output  WIDTH  the word offered to the selected channel; shared by all channels.
REQ-012 sel_err  output  1  sticky flag: an invalid select code was received.
REQ-013 drop_cnt  output  8  count of words dropped because of an invalid select code.

Function
REQ-014 An input transfer (in_fire) SHALL occur when in_valid and in_ready are both 1 at a clock edge.
REQ-015 An output transfer (out_fire) SHALL occur when (out_valid & out_ready) is nonzero at a clock edge.
REQ-016 The block SHALL hold two storage entries: an output register (data plus channel code) and a skid register.
REQ-017 State EMPTY: out_valid = 0; in_ready = 1.
REQ-018 State FULL: the output register is valid, and out_valid has exactly the bit for its channel code set; in_ready = 1.
REQ-019 State SKID: the output register and the skid register are both valid; in_ready = 0.
REQ-020 in_ready SHALL be derived only from state, with no combinational path from out_ready.
REQ-021 EMPTY, on a valid in_fire: load the output register and go to FULL.
- The word is offered the next cycle, so latency is 1 cycle.
REQ-022 FULL, on out_fire with a valid in_fire: replace the output register and stay in FULL, with no bubble.
REQ-023 FULL, on out_fire only: go to EMPTY.
REQ-024 FULL, on a valid in_fire only: load the skid register and go to SKID.
REQ-025 FULL, with neither event: hold the state.
REQ-026 SKID, on out_fire: move the skid register into the output register and go to FULL.
REQ-027 SKID, with no out_fire: hold the state.
REQ-028 Words SHALL be delivered in acceptance order, without loss or duplication.
REQ-029 out_data and the channel code SHALL remain stable while out_valid is nonzero and no out_fire occurs.
REQ-030 In EMPTY, out_data SHALL hold the last word delivered.
REQ-031 An in_fire with in_sel >= NCH SHALL be consumed and discarded.
- The state is unaffected by it, except for any concurrent out_fire.
- sel_err is set to 1.
- drop_cnt increments by 1 and saturates at 255.
REQ-032 sel_err SHALL clear only on reset.
REQ-033 out_ready bits other than the one for the currently offered channel SHALL be ignored.

Reset
REQ-034 While rst_n = 0 at a clock edge, the block SHALL take these values:
- state = EMPTY and in_ready = 1.
- out_valid = 0 and out_data = 0.
- sel_err = 0 and drop_cnt = 0.
- The skid register is invalid.
REQ-035 A reset in FULL or SKID SHALL discard the held words with no out_fire.
REQ-036 in_ready SHALL be 1 in the first cycle after reset is released.

Verification
REQ-037 Single word:
- Stimulus: after reset, in_sel=3, in_data=0x0123_4567_89AB_CDEF, out_ready=all 1.
- Response: next cycle out_valid=0x008 and out_data=0x0123456789ABCDEF; the cycle after, out_valid=0.
REQ-038 Back-to-back streaming:
- Stimulus: 10 words, sel 0..9, in_valid held high, out_ready all 1.
- Response: one word per cycle; out_valid walks 0x001..0x200; in_ready stays 1.
REQ-039 Backpressure:
- Stimulus: out_ready=0 while sending sel=5 then sel=7.
- Response: in_ready drops to 0 after the second in_fire; out_valid stays 0x020.
- Stimulus: raise out_ready[5].
- Response: next cycle out_valid=0x080 and in_ready=1; order is preserved.
REQ-040 Invalid select:
- Stimulus: send sel=12, then sel=15, then sel=2.
- Response: the two bad words are dropped with no out_valid; sel_err=1 and drop_cnt=2; the sel=2 word is delivered normally.
- Stimulus: 300 bad words.
- Response: drop_cnt=255.
REQ-041 Wrong-channel ready:
- Stimulus: offer sel=4 with only out_ready[6]=1.
- Response: no out_fire; the word is held stable until out_ready[4]=1.
REQ-042 Reset mid-operation:
- Stimulus: assert rst_n=0 in state SKID.
- Response: next cycle out_valid=0, out_data=0, in_ready=1, sel_err=0, drop_cnt=0.
